// File: rtl/usb_rx_frame_parser_if.sv
// Byte-stream bundle between the USB read FIFO, the frame parser and the command decoder.
// master = parser side, slave = FIFO / downstream side.
interface usb_rx_frame_parser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             EMPTY;
   logic             LOAD;
   logic             FIFO_VALID;
   logic [WIDTH-1:0] FIFO_DOUT;
   logic             PL_READY;
   logic             PL_VALID;
   logic [7:0]       PL_DATA;
   logic             PL_LAST;
   logic [7:0]       CMD_OUT;
   logic [7:0]       LEN_OUT;
   logic             FRAME_OK;
   logic             FRAME_ERR;

   modport master (
      input  EMPTY, FIFO_VALID, FIFO_DOUT, PL_READY,
      output LOAD, PL_VALID, PL_DATA, PL_LAST, CMD_OUT, LEN_OUT, FRAME_OK, FRAME_ERR
   );

   modport slave (
      output EMPTY, FIFO_VALID, FIFO_DOUT, PL_READY,
      input  LOAD, PL_VALID, PL_DATA, PL_LAST, CMD_OUT, LEN_OUT, FRAME_OK, FRAME_ERR
   );
endinterface

// File: rtl/usb_rx_frame_parser.sv
// USB read-FIFO frame parser: hunts HEAD0/HEAD1, parses CMD/LEN, streams payload, checks 8-bit sum.
// Optional in-frame idle abort enabled by defining USB_RX_PARSER_TIMEOUT_EN.
module usb_rx_frame_parser #(
   parameter int unsigned WIDTH   = 8,
   parameter logic [7:0]  HEAD0   = 8'hEB,
   parameter logic [7:0]  HEAD1   = 8'h90,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   usb_rx_frame_parser_if.master bus
);
   typedef enum logic [2:0] {HUNT0, HUNT1, CMD, LEN, PAYLOAD, CSUM} state_e;

   state_e     state_q, state_d;
   logic       rd_pending_q, rd_pending_d;
   logic [7:0] sum_q, sum_d;
   logic [7:0] count_q, count_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] len_q, len_d;
   logic [7:0] pl_data_q, pl_data_d;
   logic       pl_valid_q, pl_valid_d;
   logic       pl_last_q, pl_last_d;
   logic       ok_q, ok_d;
   logic       err_q, err_d;
   logic       byte_v;
   logic       load;
   logic [7:0] rx_byte;

   if (WIDTH != 8 || TIMEOUT < 2) begin : g_param_check
      $error("usb_rx_frame_parser: WIDTH must be 8 and TIMEOUT at least 2");
   end

`ifdef USB_RX_PARSER_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT - 2);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   logic          in_frame;
`endif

   assign rx_byte = bus.FIFO_DOUT;
   assign byte_v  = bus.FIFO_VALID && rd_pending_q;
   assign load    = !bus.EMPTY && !rd_pending_q && bus.PL_READY && sys_rst_n;

   always_comb begin
      state_d      = state_q;
      rd_pending_d = rd_pending_q;
      sum_d        = sum_q;
      count_d      = count_q;
      cmd_d        = cmd_q;
      len_d        = len_q;
      pl_data_d    = pl_data_q;
      pl_valid_d   = 1'b0;
      pl_last_d    = 1'b0;
      ok_d         = 1'b0;
      err_d        = 1'b0;

      if (byte_v) rd_pending_d = 1'b0;
      if (load)   rd_pending_d = 1'b1;

      if (byte_v) begin
         case (state_q)
            HUNT0: if (rx_byte == HEAD0) state_d = HUNT1;
            // A repeated HEAD0 may itself be the start of the real header.
            HUNT1: begin
               if (rx_byte == HEAD1)      state_d = CMD;
               else if (rx_byte != HEAD0) state_d = HUNT0;
            end
            CMD: begin
               cmd_d   = rx_byte;
               sum_d   = rx_byte;
               state_d = LEN;
            end
            LEN: begin
               len_d   = rx_byte;
               sum_d   = sum_q + rx_byte;
               count_d = rx_byte;
               state_d = (rx_byte == 8'd0) ? CSUM : PAYLOAD;
            end
            PAYLOAD: begin
               pl_valid_d = 1'b1;
               pl_data_d  = rx_byte;
               sum_d      = sum_q + rx_byte;
               count_d    = count_q - 8'd1;
               if (count_q == 8'd1) begin
                  pl_last_d = 1'b1;
                  state_d   = CSUM;
               end
            end
            CSUM: begin
               ok_d    = (rx_byte == sum_q);
               err_d   = (rx_byte != sum_q);
               state_d = HUNT0;
            end
            default: state_d = HUNT0;
         endcase
      end

`ifdef USB_RX_PARSER_TIMEOUT_EN
      // Hit one count early so the registered FRAME_ERR lands TIMEOUT cycles after the last byte.
      in_frame = (state_q != HUNT0) && (state_q != HUNT1);
      tmo_hit  = in_frame && !bus.FIFO_VALID && (tmo_q == TMO_HIT);
      tmo_d    = (bus.FIFO_VALID || !in_frame || tmo_hit) ? '0 : tmo_q + 1'b1;
      if (tmo_hit) begin
         err_d   = 1'b1;
         state_d = HUNT0;
      end
`endif
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q      <= HUNT0;
         rd_pending_q <= 1'b0;
         sum_q        <= '0;
         count_q      <= '0;
         cmd_q        <= '0;
         len_q        <= '0;
         pl_data_q    <= '0;
         pl_valid_q   <= 1'b0;
         pl_last_q    <= 1'b0;
         ok_q         <= 1'b0;
         err_q        <= 1'b0;
`ifdef USB_RX_PARSER_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rd_pending_q <= rd_pending_d;
         sum_q        <= sum_d;
         count_q      <= count_d;
         cmd_q        <= cmd_d;
         len_q        <= len_d;
         pl_data_q    <= pl_data_d;
         pl_valid_q   <= pl_valid_d;
         pl_last_q    <= pl_last_d;
         ok_q         <= ok_d;
         err_q        <= err_d;
`ifdef USB_RX_PARSER_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign bus.LOAD      = load;
   assign bus.PL_VALID  = pl_valid_q;
   assign bus.PL_DATA   = pl_data_q;
   assign bus.PL_LAST   = pl_last_q;
   assign bus.CMD_OUT   = cmd_q;
   assign bus.LEN_OUT   = len_q;
   assign bus.FRAME_OK  = ok_q;
   assign bus.FRAME_ERR = err_q;
endmodule

// File: tb/tb_usb_rx_frame_parser.sv
// Directed bench for usb_rx_frame_parser: FIFO model with 1-cycle read latency, payload/pulse monitor.
// Timeout case built only when USB_RX_PARSER_TIMEOUT_EN is defined.
module tb_usb_rx_frame_parser;
   typedef logic [7:0] bq_t [$];

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic ld = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_fv_cyc = 0;
   int   err_cyc = 0;
   int   ok_cnt = 0;
   int   err_cnt = 0;
   bq_t  fifo_q;
   bq_t  inject_q;
   bq_t  stim;
   bq_t  expq;
   logic [8:0] pl_obs [$];

   usb_rx_frame_parser_if #(.WIDTH(8)) bus ();

   usb_rx_frame_parser #(
      .WIDTH(8), .HEAD0(8'hEB), .HEAD1(8'h90), .TIMEOUT(16)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Read FIFO: data follows LOAD by one cycle; inject_q drives unsolicited FIFO_VALID.
   initial begin
      bus.FIFO_VALID = 1'b0;
      bus.FIFO_DOUT  = 8'h00;
      bus.EMPTY      = 1'b1;
      forever begin
         @(negedge sys_clk);
         ld = bus.LOAD;
         @(posedge sys_clk);
         #1;
         bus.FIFO_VALID = 1'b0;
         if (ld) begin
            bus.FIFO_VALID = 1'b1;
            if (fifo_q.size() > 0) bus.FIFO_DOUT = fifo_q.pop_front();
            else                   bus.FIFO_DOUT = 8'h00;
         end else if (inject_q.size() > 0) begin
            bus.FIFO_VALID = 1'b1;
            bus.FIFO_DOUT  = inject_q.pop_front();
         end
         bus.EMPTY = (fifo_q.size() == 0);
      end
   end

   always @(negedge sys_clk) begin
      cyc++;
      if (bus.FIFO_VALID) last_fv_cyc = cyc;
      if (bus.PL_VALID) pl_obs.push_back({bus.PL_LAST, bus.PL_DATA});
      if (bus.FRAME_OK) ok_cnt++;
      if (bus.FRAME_ERR) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.FRAME_OK || bus.FRAME_ERR) check("pulse_vs_plvalid", 32'(bus.PL_VALID), 32'd0);
   end

   task automatic clear_obs();
      pl_obs.delete();
      ok_cnt  = 0;
      err_cnt = 0;
   endtask

   task automatic check_pl(input string tag, input bq_t exp_pl);
      check({tag, "_pl_count"}, 32'(pl_obs.size()), 32'(exp_pl.size()));
      foreach (exp_pl[i])
         if (i < pl_obs.size())
            check({tag, "_pl"}, 32'(pl_obs[i]), 32'({(i == exp_pl.size() - 1), exp_pl[i]}));
   endtask

   task automatic run_frame(input string tag, input bq_t s, input bq_t exp_pl,
                            input logic [7:0] exp_cmd, input logic [7:0] exp_len,
                            input int exp_ok, input int exp_err);
      clear_obs();
      foreach (s[i]) fifo_q.push_back(s[i]);
      repeat (s.size() * 2 + 12) @(posedge sys_clk);
      @(negedge sys_clk);
      check({tag, "_drain"}, 32'(fifo_q.size()), 32'd0);
      check_pl(tag, exp_pl);
      check({tag, "_cmd"}, 32'(bus.CMD_OUT), 32'(exp_cmd));
      check({tag, "_len"}, 32'(bus.LEN_OUT), 32'(exp_len));
      check({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
      check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
   endtask

   initial begin
      bus.PL_READY = 1'b1;
      sys_rst_n    = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_load", 32'(bus.LOAD), 32'd0);
      check("rst_pl_valid", 32'(bus.PL_VALID), 32'd0);
      check("rst_pl_last", 32'(bus.PL_LAST), 32'd0);
      check("rst_pl_data", 32'(bus.PL_DATA), 32'd0);
      check("rst_cmd", 32'(bus.CMD_OUT), 32'd0);
      check("rst_len", 32'(bus.LEN_OUT), 32'd0);
      check("rst_ok", 32'(bus.FRAME_OK), 32'd0);
      check("rst_err", 32'(bus.FRAME_ERR), 32'd0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      repeat (2) @(posedge sys_clk);

      // 01+03+11+22+33 = 6A
      stim = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      expq = '{8'h11, 8'h22, 8'h33};
      run_frame("good", stim, expq, 8'h01, 8'h03, 1, 0);

      stim = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
      run_frame("badck", stim, expq, 8'h01, 8'h03, 0, 1);

      stim = '{8'hEB, 8'h90, 8'h05, 8'h00, 8'h05};
      expq.delete();
      run_frame("zlen", stim, expq, 8'h05, 8'h00, 1, 0);

      // 02+01+AA = AD
      stim = '{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h02, 8'h01, 8'hAA, 8'hAD};
      expq = '{8'hAA};
      run_frame("resync", stim, expq, 8'h02, 8'h01, 1, 0);

      // Unsolicited header bytes must not advance the parser.
      inject_q = '{8'hEB, 8'h90, 8'h01};
      repeat (8) @(posedge sys_clk);
      stim = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      expq = '{8'h11, 8'h22, 8'h33};
      run_frame("stray", stim, expq, 8'h01, 8'h03, 1, 0);

      // 03+04+A1+B2+C3+D4 = F1 (mod 256)
      clear_obs();
      stim = '{8'hEB, 8'h90, 8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hF1};
      foreach (stim[i]) fifo_q.push_back(stim[i]);
      for (int i = 0; i < 100 && pl_obs.size() < 2; i++) @(posedge sys_clk);
      check("bp_reach", 32'(pl_obs.size() >= 2), 32'd1);
      #1 bus.PL_READY = 1'b0;
      repeat (20) begin
         @(negedge sys_clk);
         check("bp_load", 32'(bus.LOAD), 32'd0);
      end
      @(posedge sys_clk);
      #1 bus.PL_READY = 1'b1;
      repeat (30) @(posedge sys_clk);
      @(negedge sys_clk);
      expq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      check_pl("bp", expq);
      check("bp_ok", 32'(ok_cnt), 32'd1);
      check("bp_err", 32'(err_cnt), 32'd0);

      // Reset mid-payload: frame discarded, registers cleared, no pulses.
      clear_obs();
      stim = '{8'hEB, 8'h90, 8'h07, 8'h02, 8'h11};
      foreach (stim[i]) fifo_q.push_back(stim[i]);
      for (int i = 0; i < 100 && pl_obs.size() < 1; i++) @(posedge sys_clk);
      check("mrst_reach", 32'(pl_obs.size()), 32'd1);
      #1 sys_rst_n = 1'b0;
      fifo_q.delete();
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      check("mrst_cmd", 32'(bus.CMD_OUT), 32'd0);
      check("mrst_len", 32'(bus.LEN_OUT), 32'd0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      repeat (10) @(posedge sys_clk);
      @(negedge sys_clk);
      check("mrst_ok", 32'(ok_cnt), 32'd0);
      check("mrst_err", 32'(err_cnt), 32'd0);
      stim = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      expq = '{8'h11, 8'h22, 8'h33};
      run_frame("mrst_after", stim, expq, 8'h01, 8'h03, 1, 0);

`ifdef USB_RX_PARSER_TIMEOUT_EN
      clear_obs();
      stim = '{8'hEB, 8'h90, 8'h01, 8'h04, 8'h11};
      foreach (stim[i]) fifo_q.push_back(stim[i]);
      repeat (50) @(posedge sys_clk);
      @(negedge sys_clk);
      expq = '{8'h11};
      check("tmo_pl_count", 32'(pl_obs.size()), 32'd1);
      if (pl_obs.size() > 0) check("tmo_pl", 32'(pl_obs[0]), 32'h011);
      check("tmo_err", 32'(err_cnt), 32'd1);
      check("tmo_ok", 32'(ok_cnt), 32'd0);
      check("tmo_delay", 32'(err_cyc - last_fv_cyc), 32'd16);
      stim = '{8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      expq = '{8'h11, 8'h22, 8'h33};
      run_frame("tmo_after", stim, expq, 8'h01, 8'h03, 1, 0);
`else
      // Starved mid-frame: parser just waits, then completes.
      clear_obs();
      stim = '{8'hEB, 8'h90, 8'h01, 8'h01};
      foreach (stim[i]) fifo_q.push_back(stim[i]);
      repeat (60) @(posedge sys_clk);
      @(negedge sys_clk);
      check("stall_err", 32'(err_cnt), 32'd0);
      check("stall_ok", 32'(ok_cnt), 32'd0);
      stim = '{8'h22, 8'h24};
      expq = '{8'h22};
      run_frame("stall_resume", stim, expq, 8'h01, 8'h01, 1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/usb_rx_frame_parser.md
Name: usb_rx_frame_parser

Overview:
- Downstream consumer of the USB-to-system read FIFO (FIFO_DOUT/FIFO_VALID/LOAD/EMPTY side of the FT232 sync bridge), in the sys_clk domain.
- Pops host bytes and hunts for frame header 0xEB 0x90. Parses CMD and LEN, streams the payload, then checks an 8-bit additive checksum.
- Reports each frame as good or bad to the command-decode logic.

Parameters:
- WIDTH, 8, byte width of FIFO_DOUT; must be 8.
- HEAD0, 8'hEB, first header byte.
- HEAD1, 8'h90, second header byte.
- TIMEOUT, 1024, idle sys_clk cycles before an in-frame abort (only with the optional feature).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- EMPTY  in  1  read FIFO empty.
- LOAD  out  1  read-FIFO pop request, single-cycle pulse.
- FIFO_VALID  in  1  FIFO_DOUT valid; arrives exactly 1 cycle after LOAD.
- FIFO_DOUT  in  WIDTH  popped byte.
- PL_READY  in  1  downstream can accept payload; gates LOAD.
- PL_VALID  out  1  payload byte strobe.
- PL_DATA  out  8  payload byte.
- PL_LAST  out  1  with PL_VALID, marks final payload byte.
- CMD_OUT  out  8  command byte of the current/last frame.
- LEN_OUT  out  8  payload length of the current/last frame.
- FRAME_OK  out  1  1-cycle pulse: checksum matched.
- FRAME_ERR  out  1  1-cycle pulse: checksum mismatch or timeout abort.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge):
  - State = HUNT0, rd_pending=0, sum=0, count=0.
  - All outputs 0, including CMD_OUT and LEN_OUT.
  - Reset mid-frame discards the partial frame and issues no pulses.
- Read handshake:
  - LOAD = !EMPTY && !rd_pending && PL_READY && sys_rst_n.
  - rd_pending is set the cycle LOAD is high and cleared when FIFO_VALID arrives, so at most one read is outstanding.
  - Maximum throughput is 1 byte per 2 cycles.
  - FIFO_VALID with no pending read is ignored.
- All byte processing occurs on cycles where FIFO_VALID=1.
- State machine:
  - HUNT0: byte==HEAD0 -> HUNT1; else stay.
  - HUNT1: byte==HEAD1 -> CMD; byte==HEAD0 -> stay in HUNT1; else -> HUNT0.
  - CMD: CMD_OUT<=byte; sum<=byte -> LEN.
  - LEN: LEN_OUT<=byte; sum<=sum+byte; count<=byte. If byte==0 -> CSUM, else -> PAYLOAD.
  - PAYLOAD:
    - PL_VALID=1 and PL_DATA=byte, registered, appearing the cycle after FIFO_VALID.
    - sum<=sum+byte; count<=count-1.
    - PL_LAST=1 when count==1, then -> CSUM.
  - CSUM: if byte==sum, pulse FRAME_OK, else pulse FRAME_ERR, one cycle after FIFO_VALID -> HUNT0.
- Arithmetic: sum is modulo 256 and covers CMD, LEN and payload only, never the header.
- Payload semantics:
  - Payload is streamed before it is validated; consumers must discard it on FRAME_ERR.
  - FRAME_OK/FRAME_ERR never coincide with PL_VALID.
- CMD_OUT and LEN_OUT hold their values until the next frame's CMD/LEN bytes.
- A header pattern inside the payload is treated as payload; there is no resync inside a frame.
- Backpressure: PL_READY=0 stalls new pops in every state. A read already pending still completes and is processed.
- EMPTY mid-frame simply stalls; without the optional feature there is no abort.

Optional Feature:
- Macro: USB_RX_PARSER_TIMEOUT_EN.
- When defined:
  - A counter counts sys_clk cycles since the last FIFO_VALID while the state is not HUNT0/HUNT1.
  - When it reaches TIMEOUT, FRAME_ERR pulses once, state -> HUNT0, and the counter clears.
  - The counter also clears on every FIFO_VALID and on reset.
- When undefined: no counter logic; the parser waits indefinitely inside a frame.

Test Plan:
- Frame EB 90 01 03 11 22 33 CK=0x6A:
  - PL_DATA 11,22,33; PL_LAST on 33.
  - CMD_OUT=01, LEN_OUT=03.
  - One FRAME_OK, no FRAME_ERR.
- Same frame with CK=0x6B -> payload still streamed, one FRAME_ERR, no FRAME_OK.
- Zero-length frame EB 90 05 00 05 -> no PL_VALID, FRAME_OK; LEN_OUT=00.
- Garbage 00 EB EB 90 02 01 AA AD:
  - Sync recovers via the HUNT1 self-loop.
  - PL_DATA=AA with PL_LAST; FRAME_OK.
- PL_READY held 0 for 20 cycles mid-payload with EMPTY=0 -> LOAD stays 0 after the pending read; resumes with no byte lost or duplicated.
- With USB_RX_PARSER_TIMEOUT_EN and TIMEOUT=16: send EB 90 01 04 11, then EMPTY=1 -> FRAME_ERR exactly 16 cycles after the last FIFO_VALID. A following good frame returns FRAME_OK.
